// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle between the fetch stage, the fetch queue and decode.
// The master side is the fetch stage/decode environment; the slave side is the queue.
// XLEN normally comes from general_defines; the fallback keeps this file standalone.

`ifndef XLEN
`define XLEN 32
`endif

interface fetch_queue_if #(
    parameter int DEPTH = 8,
    parameter int ILEN  = 32
);
    logic                         in_valid;
    logic [`XLEN-1:0]             in_pc;
    logic [ILEN-1:0]              in_instr;
    logic                         fetch_stall;
    logic                         flush;
    logic                         out_valid;
    logic [`XLEN-1:0]             out_pc;
    logic [ILEN-1:0]              out_instr;
    logic                         out_ready;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         overflow;

    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  fetch_stall, out_valid, out_pc, out_instr, count, overflow
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output fetch_stall, out_valid, out_pc, out_instr, count, overflow
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of {pc, instr} pairs between fetch and decode.
// Raises fetch_stall when only SKID free slots remain, drops (and flags) entries
// that arrive when full, and empties on flush.
// Optional build macro FETCH_QUEUE_BYPASS_EN: when empty, an arriving entry is
// presented to decode in the same cycle (and consumed without a write if taken).

`ifndef XLEN
`define XLEN 32
`endif

module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int ILEN  = 32,
    parameter int SKID  = 1
) (
    input logic         clk,
    input logic         rst,
    fetch_queue_if.slave fq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_COUNT = CW'(DEPTH - SKID);

    logic [`XLEN-1:0] pc_mem    [DEPTH];
    logic [ILEN-1:0]  instr_mem [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    logic queue_valid;
    logic pop;
    logic push;
    logic drop;
    logic bypass_take;

    assign queue_valid = (count_q != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit    = !queue_valid && fq.in_valid && !fq.flush;
    assign bypass_take   = bypass_hit && fq.out_ready;
    assign fq.out_valid  = queue_valid || bypass_hit;
    assign fq.out_pc     = bypass_hit ? fq.in_pc    : pc_mem[rd_ptr];
    assign fq.out_instr  = bypass_hit ? fq.in_instr : instr_mem[rd_ptr];
`else
    assign bypass_take   = 1'b0;
    assign fq.out_valid  = queue_valid;
    assign fq.out_pc     = pc_mem[rd_ptr];
    assign fq.out_instr  = instr_mem[rd_ptr];
`endif

    // A bypassed entry never touches storage, so it is excluded from push and drop.
    assign pop  = queue_valid && fq.out_ready && !fq.flush;
    assign push = fq.in_valid && !fq.flush && !bypass_take && ((count_q < FULL_COUNT) || pop);
    assign drop = fq.in_valid && !fq.flush && !bypass_take && !push;

    assign fq.fetch_stall = (count_q >= STALL_COUNT);
    assign fq.count       = count_q;
    assign fq.overflow    = overflow_q;

    // Storage write at the tail; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= fq.in_pc;
            instr_mem[wr_ptr] <= fq.in_instr;
        end
    end

    // Pointer, occupancy and sticky overflow bookkeeping; rst beats flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (fq.flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Consumer end of the fetch PC stream.
- Buffers {pc, instr} pairs delivered by the fetch stage / instruction memory and presents them in order to decode over a valid/ready handshake.
- Drives the fetch stall line back to the PC generator when nearly full, and discards all contents on pipeline flush.
- Sits between the fetch stage and decode.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 4.
- ILEN, 32, instruction width in bits.
- SKID, 1, free slots reserved for in-flight fetches when fetch_stall is raised; 0 <= SKID < DEPTH.
- XLEN comes from general_defines (not a parameter).

Ports:
- clk  input  1  clock
- rst  input  1  reset
- in_valid  input  1  fetch delivers one entry this cycle
- in_pc  input  XLEN  PC of the delivered entry
- in_instr  input  ILEN  instruction of the delivered entry
- fetch_stall  output  1  to fetch stage stall input; hold the PC
- flush  input  1  discard all entries (same flush sent to fetch)
- out_valid  output  1  head entry available to decode
- out_pc  output  XLEN  head entry PC
- out_instr  output  ILEN  head entry instruction
- out_ready  input  1  decode accepts the head entry
- count  output  $clog2(DEPTH+1)  current occupancy
- overflow  output  1  sticky: an entry was dropped

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - count=0, read/write pointers=0, overflow=0, out_valid=0.
  - fetch_stall = (0 >= DEPTH-SKID), i.e. 0 for legal parameters.
  - Storage contents are don't-care.
  - rst in mid-operation has the same effect as reset from idle and overrides flush.
- Storage: circular buffer with log2(DEPTH)-bit read/write pointers. Pointers wrap from DEPTH-1 to 0.
- pop = out_valid && out_ready && !flush.
- push = in_valid && !flush && (count < DEPTH || pop).
  - Push is accepted when full only if a pop occurs in the same cycle.
- count_next = count + push - pop. It never exceeds DEPTH and never underflows.
- fetch_stall = (count >= DEPTH-SKID). It is purely a function of registered count, so there is no combinational path from in_valid or out_ready.
- out_valid = (count != 0). out_pc/out_instr read combinationally from the head slot; they are don't-care when out_valid=0.
- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1 (non-bypass build).
- Order: strict FIFO. Simultaneous push and pop at any occupancy updates both pointers; count is unchanged.
- Drop: in_valid && !flush && !push leaves state unchanged and sets overflow=1. overflow clears only on rst, not on flush.
- Flush: takes priority over push and pop.
  - Next cycle: count=0, pointers=0, out_valid=0, fetch_stall=0.
  - Same-cycle in_valid is discarded without setting overflow.
  - Same-cycle out_ready produces no pop, because flush masks out_valid from being consumed.
- Decode contract: out_pc/out_instr must stay stable while out_valid && !out_ready && !flush. They are stable because the head does not move without a pop.

Optional Feature:
FETCH_QUEUE_BYPASS_EN:
- Defined: when count==0, in_valid=1 and flush=0:
  - out_valid=1 combinationally, with out_pc=in_pc and out_instr=in_instr.
  - If out_ready=1, the entry is consumed without being written: count stays 0 and pointers are unchanged.
  - If out_ready=0, the entry is pushed normally.
  - Zero-cycle latency when empty.
- Undefined: no in-to-out combinational path; minimum latency is 1 cycle as described above.

Test Plan:
- Reset, then push 3 entries (pc 0x0, 0x4, 0x8; instr 0xA0,0xA1,0xA2) with out_ready=0 -> count=3, out_pc=0x0. Then set out_ready=1 -> pops 0x0, 0x4, 0x8 on consecutive cycles, then out_valid=0.
- DEPTH=8, SKID=1, push 7 entries with out_ready=0 -> fetch_stall=1 when count=7. Push the 8th -> count=8. Push a 9th -> dropped, count stays 8, overflow=1.
- Full queue (count=8), in_valid=1 and out_ready=1 in the same cycle -> count stays 8, head advances by one entry, the new entry lands at the tail, overflow unchanged.
- Push and pop continuously for 20 cycles with pc incrementing by 4 -> out_pc sequence strictly increasing by 4 across pointer wrap, count constant at 1.
- count=5, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, fetch_stall=0, overflow unchanged. Push pc 0x100 -> it appears at the head.
- Bypass build: empty queue, in_valid=1, pc 0x40, out_ready=1 -> out_valid=1 and out_pc=0x40 in the same cycle, count stays 0. Non-bypass build -> out_valid=0 that cycle, 1 the next.
